// File: rtl/vga_timing_recovery.sv
// Rebuilds hcount/vcount from an active-high VGA sync/blank bundle, measures line and
// frame geometry, and locks when the stream matches the expected mode.
module vga_timing_recovery #(
   parameter int H_TOTAL      = 1056,
   parameter int H_SYNC_START = 840,
   parameter int H_SYNC_TIME  = 128,
   parameter int V_TOTAL      = 628,
   parameter int V_SYNC_START = 601,
   parameter int V_SYNC_TIME  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hsync,
   input  logic        vsync,
   input  logic        hblnk,
   input  logic        vblnk,
   output logic [10:0] rec_hcount,
   output logic [10:0] rec_vcount,
   output logic        locked,
   output logic        err,
   output logic [7:0]  err_cnt,
   output logic [11:0] h_total_meas,
   output logic [11:0] v_total_meas
);

   typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
   state_t state, state_nxt;

   logic        hsync_s, vsync_s, hblnk_s, vblnk_s;
   logic        hsync_d, vsync_d, hblnk_d, vblnk_d;
   logic [11:0] line_cnt, v_cnt, hs_len;
   logic [11:0] h_next, v_next;
   logic        hs_seen, vs_seen;
   logic        line_start, frame_start, hs_rise, hs_fall, vs_rise, vs_fall;
   logic        los, viol, err_nxt;

   assign line_start  = hblnk_d & ~hblnk_s;
   assign frame_start = line_start & vblnk_d & ~vblnk_s;
   assign hs_rise     = hsync_s & ~hsync_d;
   assign hs_fall     = ~hsync_s & hsync_d;
   assign vs_rise     = vsync_s & ~vsync_d;
   assign vs_fall     = ~vsync_s & vsync_d;

   // Counters saturate at 4095; a saturated line counter means the sync stream is gone.
   always_comb begin
      h_next = 12'd0;
      v_next = v_cnt;
      if (!line_start)
         h_next = (line_cnt == 12'hFFF) ? 12'hFFF : line_cnt + 12'd1;
      if (frame_start)
         v_next = 12'd0;
      else if (line_start && v_cnt != 12'hFFF)
         v_next = v_cnt + 12'd1;
   end

   assign los = (h_next == 12'hFFF);

   // All checks use the values being loaded into the recovered counters, so they line
   // up with the source counts of the sample that produced the edge.
   always_comb begin
      viol = 1'b0;
      if (line_start && (line_cnt + 12'd1 != 12'(H_TOTAL))) viol = 1'b1;
      if (line_start && !hs_seen) viol = 1'b1;
      if (hs_rise && h_next != 12'(H_SYNC_START)) viol = 1'b1;
      if (hs_fall && hs_len != 12'(H_SYNC_TIME)) viol = 1'b1;
      if (vs_rise && !(line_start && v_next == 12'(V_SYNC_START))) viol = 1'b1;
      if (vs_fall && !(line_start && v_next == 12'(V_SYNC_START + V_SYNC_TIME))) viol = 1'b1;
      if (frame_start && (v_cnt + 12'd1 != 12'(V_TOTAL))) viol = 1'b1;
      if (frame_start && !vs_seen) viol = 1'b1;
   end

   always_comb begin
      state_nxt = state;
      err_nxt   = 1'b0;
      case (state)
         SEARCH:  if (frame_start) state_nxt = MEASURE;
         MEASURE: begin
            if (los || viol) state_nxt = SEARCH;
            else if (frame_start) state_nxt = LOCKED;
         end
         LOCKED: begin
            if (los) state_nxt = SEARCH;
            else if (viol) begin
               state_nxt = SEARCH;
               err_nxt   = 1'b1;
            end
         end
         default: state_nxt = SEARCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= SEARCH;
         hsync_s      <= 1'b0;
         vsync_s      <= 1'b0;
         hblnk_s      <= 1'b0;
         vblnk_s      <= 1'b0;
         hsync_d      <= 1'b0;
         vsync_d      <= 1'b0;
         hblnk_d      <= 1'b0;
         vblnk_d      <= 1'b0;
         line_cnt     <= 12'd0;
         v_cnt        <= 12'd0;
         hs_len       <= 12'd0;
         hs_seen      <= 1'b0;
         vs_seen      <= 1'b0;
         err          <= 1'b0;
         err_cnt      <= 8'd0;
         h_total_meas <= 12'd0;
         v_total_meas <= 12'd0;
      end else begin
         state    <= state_nxt;
         hsync_s  <= hsync;
         vsync_s  <= vsync;
         hblnk_s  <= hblnk;
         vblnk_s  <= vblnk;
         hsync_d  <= hsync_s;
         vsync_d  <= vsync_s;
         hblnk_d  <= hblnk_s;
         vblnk_d  <= vblnk_s;
         line_cnt <= h_next;
         v_cnt    <= v_next;
         if (hs_rise) hs_len <= 12'd1;
         else if (hsync_s && hs_len != 12'hFFF) hs_len <= hs_len + 12'd1;
         hs_seen <= hs_rise | (hs_seen & ~line_start);
         vs_seen <= vs_rise | (vs_seen & ~frame_start);
         err     <= err_nxt;
         if (err_nxt && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
         if (line_start)  h_total_meas <= line_cnt + 12'd1;
         if (frame_start) v_total_meas <= v_cnt + 12'd1;
      end
   end

   assign rec_hcount = line_cnt[10:0];
   assign rec_vcount = v_cnt[10:0];
   assign locked     = (state == LOCKED);

endmodule

// File: tb/tb_vga_timing_recovery.sv
// Bench for vga_timing_recovery on a scaled-down 20x8 mode so whole frames stay short.
module tb_vga_timing_recovery;

   localparam int HT = 20, H_ACT = 12, HSS = 14, HST = 3;
   localparam int VT = 8, V_ACT = 5, VSS = 6, VST = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic hsync = 1'b0, vsync = 1'b0, hblnk = 1'b0, vblnk = 1'b0;
   logic [10:0] rec_hcount, rec_vcount, rec_hcount2, rec_vcount2;
   logic        locked, err, locked2, err2;
   logic [7:0]  err_cnt, err_cnt2;
   logic [11:0] h_meas, v_meas, h_meas2, v_meas2;

   always #12.5 clk = ~clk;

   vga_timing_recovery #(.H_TOTAL(HT), .H_SYNC_START(HSS), .H_SYNC_TIME(HST),
                         .V_TOTAL(VT), .V_SYNC_START(VSS), .V_SYNC_TIME(VST)) dut (
      .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .hblnk(hblnk), .vblnk(vblnk),
      .rec_hcount(rec_hcount), .rec_vcount(rec_vcount), .locked(locked), .err(err),
      .err_cnt(err_cnt), .h_total_meas(h_meas), .v_total_meas(v_meas));

   // Same stream, wrong expected line length: must never lock.
   vga_timing_recovery #(.H_TOTAL(HT - 1), .H_SYNC_START(HSS), .H_SYNC_TIME(HST),
                         .V_TOTAL(VT), .V_SYNC_START(VSS), .V_SYNC_TIME(VST)) dut2 (
      .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .hblnk(hblnk), .vblnk(vblnk),
      .rec_hcount(rec_hcount2), .rec_vcount(rec_vcount2), .locked(locked2), .err(err2),
      .err_cnt(err_cnt2), .h_total_meas(h_meas2), .v_total_meas(v_meas2));

   typedef struct {
      int stretch_line;
      int short_line;
      int exp_errs;
      bit exp_locked;
      int exp_err_cnt;
      int exp_h_max;
      int exp_v_meas;
   } row_t;

   row_t rows[11];

   logic [22:0] exp_q[$];
   int  checks = 0, errors = 0;
   int  cyc = 0, rst_at = -10, rise_cyc = -1;
   int  err_pulses = 0, err2_pulses = 0, h_max = 0;
   bit  chk_rec = 1'b0, locked_prev = 1'b0, locked2_ever = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One pixel clock: drive the source at (h, v), then sample the DUT mid-cycle.
   task automatic step(input int h, input int v, input int hs_time, input bit live);
      logic [22:0] e;
      @(posedge clk);
      #1;
      rst = (cyc == rst_at);
      if (rst) begin
         exp_q.delete();
         chk_rec = 1'b0;
      end
      if (live) begin
         hblnk = (h >= H_ACT);
         hsync = (h >= HSS) && (h < HSS + hs_time);
         vblnk = (v >= V_ACT);
         vsync = (v >= VSS) && (v < VSS + VST);
      end else begin
         hblnk = 1'b0;
         hsync = 1'b0;
         vblnk = 1'b0;
         vsync = 1'b0;
      end
      exp_q.push_back({chk_rec, 11'(v), 11'(h)});
      @(negedge clk);
      if (exp_q.size() == 3) begin
         e = exp_q.pop_front();
         if (e[22]) begin
            check("rec_hcount", rec_hcount, e[10:0]);
            check("rec_vcount", rec_vcount, e[21:11]);
         end
      end
      if (cyc == rst_at + 1) begin
         check("mid_rst_counts", {rec_hcount, rec_vcount}, 0);
         check("mid_rst_flags", {locked, err, err_cnt}, 0);
         check("mid_rst_meas", {h_meas, v_meas}, 0);
      end
      if (err) err_pulses++;
      if (err2) err2_pulses++;
      if (locked2) locked2_ever = 1'b1;
      if (locked && !locked_prev && rise_cyc < 0) rise_cyc = cyc;
      locked_prev = locked;
      if (int'(h_meas) > h_max) h_max = int'(h_meas);
      cyc++;
   endtask

   task automatic run_line(input int v, input int len, input int hs_time);
      for (int h = 0; h < len; h++) step(h, v, hs_time, 1'b1);
   endtask

   task automatic run_frame(input int stretch_line, input int short_line);
      for (int v = 0; v < VT; v++)
         run_line(v, (v == stretch_line) ? HT + 1 : HT, (v == short_line) ? HST - 1 : HST);
   endtask

   initial begin
      int base;
      rows[0]  = '{-1, -1, 0, 1'b1, 0, 20, 8};
      rows[1]  = '{ 3, -1, 1, 1'b0, 1, 21, 8};
      rows[2]  = '{-1, -1, 0, 1'b0, 1, 20, 8};
      rows[3]  = '{-1, -1, 0, 1'b1, 1, 20, 8};
      rows[4]  = '{-1,  2, 1, 1'b0, 2, 20, 8};
      rows[5]  = '{-1, -1, 0, 1'b0, 2, 20, 8};
      rows[6]  = '{-1, -1, 0, 1'b1, 2, 20, 8};
      rows[7]  = '{ 3, -1, 1, 1'b0, 3, 21, 8};
      rows[8]  = '{ 3, -1, 0, 1'b0, 3, 21, 8};
      rows[9]  = '{-1, -1, 0, 1'b0, 3, 20, 8};
      rows[10] = '{-1, -1, 0, 1'b1, 3, 20, 8};

      // Clock/reset block: hold reset for a few edges, then check the cleared state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_rec_hcount", rec_hcount, 0);
      check("reset_rec_vcount", rec_vcount, 0);
      check("reset_locked", locked, 0);
      check("reset_err", err, 0);
      check("reset_err_cnt", err_cnt, 0);
      check("reset_h_meas", h_meas, 0);
      check("reset_v_meas", v_meas, 0);
      check("reset_locked2", locked2, 0);

      // Initial acquisition: frame 1 start enters MEASURE, frame 2 start locks.
      run_frame(-1, -1);
      chk_rec = 1'b1;
      run_frame(-1, -1);
      check("not_locked_after_measure", locked, 0);
      run_frame(-1, -1);
      check("lock_rise_cycle", rise_cyc, 2 * HT * VT + 2);
      check("locked_after_acq", locked, 1);
      check("err_cnt_after_acq", err_cnt, 0);
      check("err_pulses_after_acq", err_pulses, 0);
      check("h_meas_after_acq", h_meas, HT);
      check("v_meas_after_acq", v_meas, VT);

      for (int r = 0; r < 11; r++) begin
         err_pulses = 0;
         h_max = 0;
         run_frame(rows[r].stretch_line, rows[r].short_line);
         check($sformatf("row%0d_err_pulses", r), err_pulses, rows[r].exp_errs);
         check($sformatf("row%0d_locked", r), locked, int'(rows[r].exp_locked));
         check($sformatf("row%0d_err_cnt", r), err_cnt, rows[r].exp_err_cnt);
         check($sformatf("row%0d_h_meas_max", r), h_max, rows[r].exp_h_max);
         check($sformatf("row%0d_v_meas", r), v_meas, rows[r].exp_v_meas);
      end

      // One-cycle reset mid-frame while locked, then full reacquisition.
      rst_at = cyc + 3 * HT + 5;
      run_frame(-1, -1);
      check("locked_after_mid_rst_frame", locked, 0);
      chk_rec = 1'b1;
      run_frame(-1, -1);
      check("locked_in_measure_after_rst", locked, 0);
      rise_cyc = -1;
      base = cyc;
      run_frame(-1, -1);
      check("relock_rise_cycle", rise_cyc, base + 2);
      check("err_cnt_after_relock", err_cnt, 0);

      // Loss of signal: four clean lines, then all inputs held low.
      err_pulses = 0;
      for (int v = 0; v < 4; v++) run_line(v, HT, HST);
      chk_rec = 1'b0;
      for (int i = 0; i < 4000; i++) step(0, 0, HST, 1'b0);
      check("los_still_locked", locked, 1);
      for (int i = 0; i < 100; i++) step(0, 0, HST, 1'b0);
      check("los_locked", locked, 0);
      check("los_err_pulses", err_pulses, 0);
      check("los_err_cnt", err_cnt, 0);
      check("los_rec_hcount", rec_hcount, 2047);
      check("los_rec_vcount", rec_vcount, 4);

      check("mismatch_locked_ever", locked2_ever, 0);
      check("mismatch_err_pulses", err2_pulses, 0);
      check("mismatch_h_meas", h_meas2, HT);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_timing_recovery.md
Name: vga_timing_recovery

Overview:
Sink-side counterpart of vga_timing. Takes the hsync/vsync/hblnk/vblnk bundle of an active-high VGA timing stream on the same pixel clock and rebuilds hcount/vcount from edges alone. It measures line and frame geometry and locks when the stream matches the expected mode. It sits downstream of any block that forwards only sync and blank signals (e.g. after a delay or overlay stage) and serves as a checker and re-counter. Defaults are 800x600 @ 40 MHz, the vga_pkg mode.

Parameters:
H_TOTAL, 1056, expected clocks per line
H_SYNC_START, 840, expected hcount at hsync rise
H_SYNC_TIME, 128, expected hsync high clocks
V_TOTAL, 628, expected lines per frame
V_SYNC_START, 601, expected vcount at vsync rise
V_SYNC_TIME, 4, expected vsync high lines

Ports:
clk  in  1  pixel clock (40 MHz)
rst  in  1  synchronous reset, active high
hsync  in  1  horizontal sync, active high
vsync  in  1  vertical sync, active high
hblnk  in  1  horizontal blank, active high
vblnk  in  1  vertical blank, active high
rec_hcount  out  11  recovered horizontal count
rec_vcount  out  11  recovered vertical count
locked  out  1  stream matches expected mode
err  out  1  one-cycle pulse on mismatch while locked
err_cnt  out  8  saturating count of err pulses
h_total_meas  out  12  last measured line length (clocks)
v_total_meas  out  12  last measured frame length (lines)

Behaviour:
- Reset is synchronous and active high. In the cycle after rst is sampled high, all outputs are 0, the FSM is in SEARCH, and the input and edge registers are 0.
- Input stage: every input is registered once (s). Edges are computed from s against s_d. Recovered counts are registered. rec_hcount/rec_vcount equal the source hcount/vcount delayed by exactly 2 clocks.
- Line start is the hblnk_s falling edge. On that edge:
  - rec_hcount <= 0 and h_total_meas <= line counter + 1.
  - If vblnk_s also falls in the same cycle: rec_vcount <= 0 and v_total_meas <= line count. Otherwise rec_vcount increments.
- At all other cycles rec_hcount increments by 1.
- Internal line counter is 12 bit and saturates at 4095. Reaching 4095 (no line start) is a loss of signal: go to SEARCH, locked=0. No err pulse is generated for loss of signal.
- Per-line checks, all evaluated with the 2-cycle-aligned counts:
  - line length == H_TOTAL
  - hsync rises at rec_hcount == H_SYNC_START
  - hsync stays high exactly H_SYNC_TIME clocks
  - vsync rises at the line start where rec_vcount == V_SYNC_START
  - vsync falls at the line start of V_SYNC_START + V_SYNC_TIME
- Per-frame check: frame length == V_TOTAL.
- A violation is any of the above failing. The first line or frame seen after SEARCH is not judged.
- FSM:
  - SEARCH: waits for the first vblnk_s fall coincident with a hblnk_s fall, then goes to MEASURE.
  - MEASURE: runs one full frame. Any violation returns to SEARCH with no err pulse. The next frame-start edge with no violations goes to LOCKED and sets locked=1 in the same cycle.
  - LOCKED: on any violation, err=1 for one cycle, err_cnt+1 (saturating at 255), locked=0, go to SEARCH.
- Simultaneous violations in one cycle produce a single err pulse.
- h_total_meas and v_total_meas update in every state.
- err_cnt clears only on rst.
- rst asserted mid-frame or mid-lock takes priority over every event in that cycle.

Test Plan:
- Drive from a vga_timing instance (40 MHz); release rst at 87.5 ns -> locked rises at the start of the second full frame (about 2 × 663168 clocks). Afterwards err stays 0, err_cnt=0, h_total_meas=1056, v_total_meas=628, and rec_hcount/rec_vcount equal the source counts delayed 2 clocks every cycle.
- While locked, stretch one hblnk by 1 clock (line of 1057) -> one err pulse, err_cnt=1, locked=0, h_total_meas=1057; relock after one clean measured frame.
- While locked, shorten one hsync pulse to 127 clocks -> err pulse, err_cnt=1, locked=0.
- While locked, force hblnk/hsync low -> after 4095 clocks locked=0, err stays 0, rec counts hold at their last values.
- Assert rst for 1 cycle mid-frame while locked -> next cycle all outputs 0, including err_cnt. Resync follows the first-scenario timing from the next frame start.
- Instantiate with H_TOTAL=1000 on the default stream -> locked never rises, err never pulses, h_total_meas=1056.
